// File: rtl/elastic_pipe_2d.sv
// elastic_pipe_2d: multi-lane elastic pipeline register with valid/ready flow control, flush and occupancy.
// Define SKID_BUF_EN to give every stage a skid register and a registered ready (doubles capacity).
module elastic_pipe_2d #(
    parameter int DATAW       = 4,
    parameter int ARRAY_DEPTH = 4,
    parameter int STAGES      = 2,
`ifdef SKID_BUF_EN
    parameter int CAP         = 2 * STAGES,
`else
    parameter int CAP         = STAGES,
`endif
    parameter int OCCW        = $clog2(CAP + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ARRAY_DEPTH-1:0] in_lane_vld,
    input  logic [DATAW-1:0]       in_data [ARRAY_DEPTH],
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ARRAY_DEPTH-1:0] out_lane_vld,
    output logic [DATAW-1:0]       out_data [ARRAY_DEPTH],
    output logic [OCCW-1:0]        occupancy
);
    localparam int DBITS = DATAW * ARRAY_DEPTH;
    localparam int BEATW = DBITS + ARRAY_DEPTH;

    // Handshake: a beat moves on valid && ready at a rising edge; valid never waits on ready,
    // and a presented head beat stays unchanged until it is taken.
    logic [BEATW-1:0]  in_beat;
    logic [BEATW-1:0]  main_d [STAGES];
    logic [STAGES-1:0] main_v;
    logic [BEATW-1:0]  src_d [STAGES];
    logic [STAGES-1:0] src_v;
    logic [STAGES:0]   rdy;
    logic              in_fire;
    logic              out_fire;

    // A beat is stored as {lane mask, lane data}; masked lanes are zeroed on entry.
    always_comb begin
        in_beat = '0;
        for (int i = 0; i < ARRAY_DEPTH; i++) begin
            in_beat[i*DATAW +: DATAW] = in_lane_vld[i] ? in_data[i] : '0;
        end
        in_beat[DBITS +: ARRAY_DEPTH] = in_lane_vld;
    end

    assign in_ready = rdy[0] && !flush && !reset;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        src_v[0] = in_fire;
        src_d[0] = in_beat;
        for (int s = 1; s < STAGES; s++) begin
            src_v[s] = main_v[s-1];
            src_d[s] = main_d[s-1];
        end
    end

`ifdef SKID_BUF_EN
    logic [STAGES-1:0] skid_v;
    logic [BEATW-1:0]  skid_d [STAGES];

    always_comb begin
        rdy[STAGES] = out_ready;
        for (int s = 0; s < STAGES; s++) begin
            rdy[s] = !skid_v[s];
        end
    end

    // The skid only fills while the main register is stalled, and it always drains first.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_v <= '0;
            skid_v <= '0;
            for (int s = 0; s < STAGES; s++) begin
                main_d[s] <= '0;
                skid_d[s] <= '0;
            end
        end else if (flush) begin
            main_v <= '0;
            skid_v <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (!main_v[s] || rdy[s+1]) begin
                    if (skid_v[s]) begin
                        main_v[s] <= 1'b1;
                        main_d[s] <= skid_d[s];
                        skid_v[s] <= 1'b0;
                    end else begin
                        main_v[s] <= src_v[s] && rdy[s];
                        if (src_v[s] && rdy[s]) main_d[s] <= src_d[s];
                    end
                end else if (src_v[s] && rdy[s]) begin
                    skid_v[s] <= 1'b1;
                    skid_d[s] <= src_d[s];
                end
            end
        end
    end
`else
    // ready[s] = !v[s] || ready[s+1], built from the output end so bubbles collapse.
    always_comb begin : ready_chain
        logic r;
        r = out_ready;
        rdy[STAGES] = r;
        for (int s = STAGES - 1; s >= 0; s--) begin
            r = !main_v[s] || r;
            rdy[s] = r;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_v <= '0;
            for (int s = 0; s < STAGES; s++) begin
                main_d[s] <= '0;
            end
        end else if (flush) begin
            main_v <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (rdy[s]) begin
                    main_v[s] <= src_v[s];
                    if (src_v[s]) main_d[s] <= src_d[s];
                end
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occupancy <= '0;
        end else if (in_fire && !out_fire) begin
            occupancy <= occupancy + OCCW'(1);
        end else if (!in_fire && out_fire) begin
            occupancy <= occupancy - OCCW'(1);
        end
    end

    assign out_valid    = main_v[STAGES-1];
    assign out_lane_vld = main_d[STAGES-1][DBITS +: ARRAY_DEPTH];

    always_comb begin
        for (int i = 0; i < ARRAY_DEPTH; i++) begin
            out_data[i] = main_d[STAGES-1][i*DATAW +: DATAW];
        end
    end
endmodule
